// File: rtl/cla_pkg.sv
// Constants shared by the 4-stage pipelined CLA adder, its result collector and the benches.
package cla_pkg;
  localparam int CLA_OPND_W  = 64;
  localparam int CLA_SUM_W   = CLA_OPND_W + 1;
  localparam int CLA_LATENCY = 4;
  localparam int CLA_DEPTH   = 8;

  typedef logic [CLA_SUM_W-1:0] cla_sum_t;
endpackage

// File: rtl/cla_sync_fifo.sv
// Synchronous FIFO whose head is held in a register, so data is visible without a read strobe.
module cla_sync_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;

  assign rd_nxt = rd_ptr + AW'(1);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      // With one entry left, the next head is the word being pushed this edge, not mem.
      if (pop) begin
        if (count > CW'(1)) head <= mem[rd_nxt];
        else if (push)      head <= din;
        else                head <= '0;
      end else if (push && count == '0) begin
        head <= din;
      end
    end
  end
endmodule

// File: rtl/cla_result_collector.sv
// Tracks real operands through the valid-less CLA adder, buffers aligned sums and
// grants credit so the buffer can never overflow.
module cla_result_collector
  import cla_pkg::*;
#(
  parameter int SUM_W   = CLA_SUM_W,
  parameter int LATENCY = CLA_LATENCY,
  parameter int DEPTH   = CLA_DEPTH,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] adder_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             err_overrun
);
  logic [LATENCY-1:0] vpipe;
  logic [CW:0]        used;
  logic               issue, pop;

  assign issue     = in_valid & in_ready;
  assign out_valid = (out_count != '0);
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      vpipe       <= '0;
      err_overrun <= 1'b0;
    end else begin
      vpipe       <= {vpipe[LATENCY-2:0], issue};
      err_overrun <= err_overrun | (in_valid & ~in_ready);
    end
  end

  // Credit counts both buffered results and those still inside the adder.
  always_comb begin
    used = {1'b0, out_count};
    for (int i = 0; i < LATENCY; i++) used = used + {{CW{1'b0}}, vpipe[i]};
  end

  assign in_ready = (used < (CW+1)'(DEPTH));

  cla_sync_fifo #(.W(SUM_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (vpipe[LATENCY-1]),
    .din   (adder_sum),
    .pop   (pop),
    .head  (out_sum),
    .count (out_count)
  );
endmodule

// File: tb/tb_cla_result_collector.sv
// Bench: pipelined-adder model feeding the collector; scoreboard queue checked by a monitor.
module tb_cla_result_collector;
  import cla_pkg::*;
  localparam int W  = CLA_SUM_W;
  localparam int CW = $clog2(CLA_DEPTH) + 1;

  logic          clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, err_overrun;
  logic [W-1:0]  adder_sum, out_sum;
  logic [CW-1:0] out_count;
  logic [63:0]   opa = '0, opb = '0;
  logic [W-1:0]  p [4];

  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, first_pop = -1, last_pop = -1;
  logic [W-1:0] exp_q [$];

  logic [63:0] ta [8] = '{64'h0, 64'h1, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0,
                          64'h00FF_00FF_00FF_00FF, 64'h7FFF_FFFF_FFFF_FFFF,
                          64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] tbv [8] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                           64'h1111_1111_1111_1111, 64'hFF00_FF00_FF00_FF00, 64'h1,
                           64'h0000_0000_CAFE_F00D, 64'h2};
  logic [W-1:0] te [8] = '{65'h0, 65'h1_0000_0000_0000_0000, 65'h1_0000_0000_0000_0001,
                           65'h0_2345_6789_ABCD_F001, 65'h0_FFFF_FFFF_FFFF_FFFF,
                           65'h0_8000_0000_0000_0000, 65'h0_DEAD_BEEF_CAFE_F00D,
                           65'h1_0000_0000_0000_0001};

  always #5 clock = ~clock;

  // Stand-in for the 4-stage adder: sum appears 4 rising edges after operands are sampled.
  always @(posedge clock) begin
    p[0] <= {1'b0, opa} + {1'b0, opb};
    for (int i = 1; i < 4; i++) p[i] <= p[i-1];
  end
  assign adder_sum = p[3];

  cla_result_collector dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .adder_sum(adder_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .err_overrun(err_overrun)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clock);
    cyc++;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL stale_sum got %h want none", out_sum);
      end else begin
        chk("out_sum", out_sum, exp_q.pop_front());
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
  end

  task automatic tick(); @(posedge clock); #1; endtask

  task automatic idle();
    in_valid = 1'b0;
    opa = {$urandom, $urandom};
    opb = {$urandom, $urandom};
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [W-1:0] e);
    in_valid = 1'b1; opa = a; opb = b;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int max);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < max) begin tick(); n++; end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL drain_timeout got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic check_clear(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_count"}, out_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_err"}, err_overrun, 0);
  endtask

  task automatic fill(input int cycles, output int acc);
    acc = 0;
    for (int i = 0; i < cycles; i++) begin
      if (in_ready) begin issue(ta[acc%8], tbv[acc%8], te[acc%8]); acc++; end
      else idle();
      tick();
    end
    idle();
  endtask

  initial begin
    int acc, stall, p0;
    logic [63:0] a, b;
    logic [W-1:0] e;
    idle();
    reset = 1'b1; tick(); tick();
    check_clear("reset");
    reset = 1'b0;

    // 1: single issue, latency and pop
    out_ready = 1'b1;
    issue(64'h1, 64'h1, 65'h2); tick(); idle();
    tick(); tick(); tick();
    chk("t1_valid_edge4", out_valid, 0);
    tick();
    chk("t1_valid_edge5", out_valid, 1);
    chk("t1_count_edge5", out_count, 1);
    tick();
    chk("t1_count_popped", out_count, 0);

    // 2: carry-out lands in bit 64
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE);
    tick(); idle();
    drain(20);

    // 3: back-pressure fills exactly DEPTH credits
    out_ready = 1'b0;
    fill(16, acc);
    tick(); tick();
    chk("t3_accepted", W'(acc), 8);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_count", out_count, 8);
    drain(30);
    chk("t3_err", err_overrun, 0);

    // 4: overrun attempt is ignored and sticky
    out_ready = 1'b0;
    fill(12, acc);
    chk("t4_in_ready", in_ready, 0);
    in_valid = 1'b1; opa = 64'h5; opb = 64'h5;
    tick(); idle(); tick();
    chk("t4_err_set", err_overrun, 1);
    repeat (6) tick();
    chk("t4_count", out_count, 8);
    drain(30);
    chk("t4_err_sticky", err_overrun, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check_clear("t4_reset");

    // 5: sustained throughput
    out_ready = 1'b1; stall = 0; p0 = pops; first_pop = -1;
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      e = {1'b0, a} + {1'b0, b};
      if (!in_ready) stall++;
      issue(a, b, e); tick();
    end
    idle();
    drain(40);
    chk("t5_stalls", W'(stall), 0);
    chk("t5_results", W'(pops - p0), 1000);
    chk("t5_span", W'(last_pop - first_pop), 999);

    // 6: reset with 5 buffered and 3 in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin issue(ta[i], tbv[i], te[i]); tick(); end
    idle();
    for (int i = 0; i < 10 && out_count != CW'(5); i++) tick();
    chk("t6_buffered", out_count, 5);
    for (int i = 5; i < 8; i++) begin issue(ta[i], tbv[i], te[i]); tick(); end
    idle();
    reset = 1'b1; tick();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_count", out_count, 0);
    chk("t6_in_ready", in_ready, 1);
    reset = 1'b0; exp_q.delete(); out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_no_stale", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
